// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge event collector with a round-robin scheduler that
// offers one pending event at a time over a valid/ready handshake.
module edge_event_arbiter #(
  parameter  int unsigned N   = 4,
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   sig,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  input  logic           evt_ready,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow,
  input  logic           clr_ovf
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   sig_dly;
  logic [N-1:0]   sig_edge;
  logic [N-1:0]   acc_mask;
  logic [N-1:0]   pending_nxt;
  logic [N-1:0]   ovf_set;
  logic [N-1:0]   overflow_nxt;
  logic [IDW-1:0] rr_ptr, rr_nxt;
  logic [IDW-1:0] id_nxt;
  logic           hs;

  // First set bit of req, searching last+1, last+2, ... wrapping, so 'last' is checked last.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0]   req,
                                             input logic [IDW-1:0] last);
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx_w;
    logic           found;
    int unsigned    idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx   = (32'(last) + i) % N;
      idx_w = IDW'(idx);
      if (!found && req[idx_w]) begin
        win   = idx_w;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign evt_valid = (state == OFFER);
  assign hs        = evt_valid & evt_ready;

  always_comb begin
    sig_edge     = sig & ~sig_dly;
    acc_mask     = hs ? (N'(1) << evt_id) : '0;
    // A same-cycle edge on the accepted channel re-arms it as a fresh event.
    pending_nxt  = (pending & ~acc_mask) | sig_edge;
    ovf_set      = sig_edge & pending & ~acc_mask;
    overflow_nxt = (overflow & ~{N{clr_ovf}}) | ovf_set;
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = evt_id;
    rr_nxt    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          id_nxt    = rr_pick(pending, rr_ptr);
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (hs) begin
          rr_nxt = evt_id;
          // Back-to-back: choose from post-update pending so new edges count too.
          if (|pending_nxt) begin
            id_nxt = rr_pick(pending_nxt, evt_id);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sig_dly  <= '1;
      pending  <= '0;
      overflow <= '0;
      state    <= IDLE;
      evt_id   <= '0;
      rr_ptr   <= IDW'(N - 1);
    end else begin
      sig_dly  <= sig;
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
      state    <= state_nxt;
      evt_id   <= id_nxt;
      rr_ptr   <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed, table-driven bench for edge_event_arbiter (N=4) with a few
// hand-written sequences for reset behaviour.
module tb_edge_event_arbiter;

  logic       clk;
  logic       rstn;
  logic [3:0] sig;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       clr_ovf;

  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct {
    logic       rstn;
    logic [3:0] sig;
    logic       rdy;
    logic       clr;
    logic       exp_valid;
    logic [1:0] exp_id;
    logic [3:0] exp_pend;
    logic [3:0] exp_ovf;
  } vec_t;

  vec_t vec [34];

  edge_event_arbiter #(.N(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sig       (sig),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .pending   (pending),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic v, input logic [1:0] id,
                           input logic [3:0] pd, input logic [3:0] ov);
    check({tag, " valid"},    32'(evt_valid), 32'(v));
    check({tag, " id"},       32'(evt_id),    32'(id));
    check({tag, " pending"},  32'(pending),   32'(pd));
    check({tag, " overflow"}, 32'(overflow),  32'(ov));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    sig       = 4'b1111;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;

    //                rstn sig    rdy clr  v  id  pend     ovf
    vec[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
    vec[1]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000};
    vec[2]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000};
    vec[3]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000};
    vec[4]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
    vec[5]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
    vec[6]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1111, 4'b0000};
    vec[7]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1111, 4'b0000};
    vec[8]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1110, 4'b0000};
    vec[9]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1100, 4'b0000};
    vec[10] = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000};
    vec[11] = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000};
    vec[12] = '{1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000};
    vec[13] = '{1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0010, 4'b0000};
    vec[14] = '{1'b1, 4'b0111, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000};
    vec[15] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1010, 4'b0000};
    vec[16] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1010, 4'b0000};
    vec[17] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1010, 4'b0000};
    vec[18] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1010, 4'b0000};
    vec[19] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1010, 4'b0000};
    vec[20] = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000};
    vec[21] = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000};
    vec[22] = '{1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000};
    vec[23] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0001, 4'b0000};
    vec[24] = '{1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000};
    vec[25] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001};
    vec[26] = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0000};
    vec[27] = '{1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000};
    vec[28] = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0001};
    vec[29] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001};
    vec[30] = '{1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001};
    vec[31] = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001};
    vec[32] = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0001};
    vec[33] = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};

    // Reset with all inputs already high: no edges after release.
    step();
    step();
    check_all("in_reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("post_rst%0d valid", i),   32'(evt_valid), 32'd0);
      check($sformatf("post_rst%0d pending", i), 32'(pending),   32'd0);
    end

    for (int i = 0; i < 34; i++) begin
      rstn      = vec[i].rstn;
      sig       = vec[i].sig;
      evt_ready = vec[i].rdy;
      clr_ovf   = vec[i].clr;
      step();
      check_all($sformatf("row%0d", i), vec[i].exp_valid, vec[i].exp_id,
                vec[i].exp_pend, vec[i].exp_ovf);
    end
    clr_ovf = 1'b0;

    // Build an offer with overflow on channels 0 and 3, then reset mid-offer.
    sig       = 4'b0110;
    evt_ready = 1'b0;
    step();
    sig = 4'b1111;
    step();
    check_all("pre_rst_pend", 1'b0, 2'd0, 4'b1001, 4'b0000);
    step();
    check_all("pre_rst_offer", 1'b1, 2'd3, 4'b1001, 4'b0000);
    sig = 4'b0110;
    step();
    sig = 4'b1111;
    step();
    check_all("pre_rst_ovf", 1'b1, 2'd3, 4'b1001, 4'b1001);
    #2;
    rstn = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 2'd0, 4'b0000, 4'b0000);
    sig = 4'b0000;
    step();
    rstn = 1'b1;
    step();
    sig = 4'b1001;
    step();
    check_all("rel_pend", 1'b0, 2'd0, 4'b1001, 4'b0000);
    step();
    check_all("rel_first", 1'b1, 2'd0, 4'b1001, 4'b0000);
    evt_ready = 1'b1;
    step();
    check_all("rel_second", 1'b1, 2'd3, 4'b1000, 4'b0000);
    step();
    check_all("rel_idle", 1'b0, 2'd3, 4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
